fc_rd_arb: RTL and testbench
============================

Name: fc_rd_arb

Overview:
- Round-robin arbiter that shares the single SRAM read port among the FC layer's three read requesters: data, weight and bias fetch.
- Grants one requester a whole burst and issues its sequential beat addresses to memory.
- Routes the in-order return data back to the owner and pulses a per-requester done.
- Sits between the FC read-control logic and the memory port. One burst is in flight at a time.

Parameters:
- N_REQ, 3, number of requesters (0 = data, 1 = weight, 2 = bias).
- ADDR_W, 28, memory word-address width.
- DATA_W, 32, read data width.
- LEN_W, 8, burst-length field width; the field carries beats-1, so 1..256 beats.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req  in  N_REQ  per-requester burst request, level
- req_addr  in  N_REQ*ADDR_W  per-requester start address, packed with requester i at [i*ADDR_W +: ADDR_W]
- req_len  in  N_REQ*LEN_W  per-requester beats-1, packed the same way
- gnt  out  N_REQ  one-hot owner of the current burst
- rvalid  out  N_REQ  one-hot return-data strobe to the owner
- rdata  out  DATA_W  return data, shared by all requesters
- done  out  N_REQ  one-cycle pulse to the owner on its last return beat
- mem_rd_en  out  1  address-phase request to memory
- mem_addr  out  ADDR_W  beat address
- mem_rd_ready  in  1  memory accepts the address when high together with mem_rd_en
- mem_rvalid  in  1  return beat valid, in order, arbitrary latency
- mem_rdata  in  DATA_W  return data
- stray_err  out  1  sticky flag: mem_rvalid arrived while no burst was outstanding

Behaviour:
- Reset (async, rst_n low):
  - state = IDLE; rr_ptr = 0.
  - gnt, rvalid, done, mem_rd_en, mem_addr, rdata and stray_err all reset to 0.
  - Reset mid-burst abandons the burst; no done pulse is produced.
- States: IDLE, ISSUE, DRAIN.
- IDLE:
  - If any req bit is high, pick the first set bit searching upward from rr_ptr, wrapping modulo N_REQ.
  - On the next edge: register gnt one-hot, latch base address and length, clear both counters, enter ISSUE.
  - Latency from req high (port idle) to gnt high is 1 cycle.
- ISSUE:
  - mem_rd_en = 1 and mem_addr = base + iss_cnt, modulo 2^ADDR_W, so the address wraps at the top of memory.
  - iss_cnt increments on each mem_rd_en && mem_rd_ready.
  - When the beat with iss_cnt == len is accepted, mem_rd_en drops on the next cycle and the state goes to DRAIN.
  - If that accept coincides with the final return beat, go straight to IDLE.
- Return path (ISSUE and DRAIN):
  - Each mem_rvalid produces rvalid = gnt and rdata = mem_rdata, registered with 1-cycle latency, and increments ret_cnt.
- Completion:
  - On the return beat where ret_cnt == len, done = gnt for exactly the cycle that beat's rvalid is high.
  - On the following cycle gnt clears to 0, rr_ptr = owner+1 (wrapping), and the state returns to IDLE.
  - Minimum gap from one done to the next gnt is 1 cycle (the IDLE arbitration cycle).
- req rules:
  - Requesters hold req high until their done; address and length are sampled only at grant.
  - req dropping mid-burst is ignored and the burst completes.
  - A requester holding req after done re-competes at its rotated priority.
- Boundary cases:
  - len = 0 gives a single-beat burst.
  - len = 2^LEN_W-1 gives a 256-beat burst; counters are LEN_W+1 bits wide.
  - mem_rd_ready low stalls issue indefinitely with mem_addr held stable.
  - Return beats may overlap issue and are never dropped. Memory must not return more than len+1 beats per burst.
  - mem_rvalid in IDLE sets stray_err (cleared only by reset) and is not forwarded.

Decomposition:
- Package fc_pkg holds:
  - localparams REQ_DATA = 0, REQ_WEIGHT = 1, REQ_BIAS = 2;
  - the state enum type for IDLE/ISSUE/DRAIN;
  - the default ADDR_W/DATA_W/LEN_W values.
- One sub-module, rr_pick: combinational round-robin priority picker with inputs req and rr_ptr and a one-hot output. It is reusable by the write-side arbiter.

Test Plan:
- Single requester: data req, addr 0x100, len 3, ready always 1, rvalid 2 cycles after each address.
  - Response: gnt=001 one cycle after req; mem_addr 0x100..0x103; four rvalid=001 beats; done=001 on the 4th beat; then IDLE.
- Round robin: all three req held high, each len 0.
  - Response: grants in order 001, 010, 100, 001; rr_ptr verified after each done.
- Backpressure: weight burst with len 7 and mem_rd_ready toggling 1/0.
  - Response: 8 accepted addresses, each held stable while stalled; no lost or duplicated beat.
- Wrap and max length: req_addr 0xFFFFFFE, len 255.
  - Response: addresses wrap to 0x0000000 after 0xFFFFFFF; exactly 256 rvalid beats; done on the last beat.
- Overlap and edge cases:
  - Final address accept in the same cycle as final return (single-beat burst, zero memory latency) -> no DRAIN state, correct done.
  - mem_rvalid pulsed in IDLE -> stray_err=1 and no rvalid.
- Reset mid-burst: rst_n low during a bias burst at beat 5 of 10.
  - Response: all outputs 0 immediately; no done; the next req is granted from rr_ptr 0.

Source files
------------

// File: rtl/fc_pkg.sv
// Shared definitions for the FC layer memory arbiters: requester ids,
// default bus widths and the arbiter state type.
package fc_pkg;

  localparam int REQ_DATA   = 0;
  localparam int REQ_WEIGHT = 1;
  localparam int REQ_BIAS   = 2;

  localparam int FC_N_REQ  = 3;
  localparam int FC_ADDR_W = 28;
  localparam int FC_DATA_W = 32;
  localparam int FC_LEN_W  = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } arb_state_t;

endpackage

// File: rtl/fc_rd_arb_rr_pick.sv
// Combinational round-robin picker: returns the first set req bit found
// searching upward from rr_ptr, wrapping modulo N_REQ, as a one-hot vector.
module rr_pick #(
  parameter int N_REQ = 3,
  parameter int PTR_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] rr_ptr,
  output logic [N_REQ-1:0] pick
);

  logic found;

  // NOTE: every output of a combinational block gets a default before any
  // conditional assignment, otherwise synthesis infers a latch.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    for (int off = 0; off < N_REQ; off++) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (!found && req[i] && ((int'(rr_ptr) + off) % N_REQ) == i) begin
          pick[i] = 1'b1;
          found   = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/fc_rd_arb.sv
// Round-robin arbiter sharing the SRAM read port between the FC data, weight
// and bias fetchers; one burst in flight, in-order return routed to the owner.
module fc_rd_arb
  import fc_pkg::*;
#(
  parameter int N_REQ  = FC_N_REQ,
  parameter int ADDR_W = FC_ADDR_W,
  parameter int DATA_W = FC_DATA_W,
  parameter int LEN_W  = FC_LEN_W
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*ADDR_W-1:0]   req_addr,
  input  logic [N_REQ*LEN_W-1:0]    req_len,
  output logic [N_REQ-1:0]          gnt,
  output logic [N_REQ-1:0]          rvalid,
  output logic [DATA_W-1:0]         rdata,
  output logic [N_REQ-1:0]          done,
  output logic                      mem_rd_en,
  output logic [ADDR_W-1:0]         mem_addr,
  input  logic                      mem_rd_ready,
  input  logic                      mem_rvalid,
  input  logic [DATA_W-1:0]         mem_rdata,
  output logic                      stray_err
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = LEN_W + 1;

  arb_state_t        state;
  logic [PTR_W-1:0]  rr_ptr;
  logic [PTR_W-1:0]  owner;
  logic [PTR_W-1:0]  next_ptr;
  logic [PTR_W-1:0]  pick_idx;
  logic [N_REQ-1:0]  pick;
  logic [ADDR_W-1:0] base;
  logic [ADDR_W-1:0] pick_addr;
  logic [LEN_W-1:0]  len;
  logic [LEN_W-1:0]  pick_len;
  logic [CNT_W-1:0]  iss_cnt;
  logic [CNT_W-1:0]  ret_cnt;
  logic              issue_acc;
  logic              last_iss;
  logic              last_ret;

  rr_pick #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_rr_pick (
    .req    (req),
    .rr_ptr (rr_ptr),
    .pick   (pick)
  );

  // Select the winner's start address and length from the packed buses.
  always_comb begin
    pick_idx  = '0;
    pick_addr = '0;
    pick_len  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick[i]) begin
        pick_idx  = PTR_W'(i);
        pick_addr = req_addr[i*ADDR_W +: ADDR_W];
        pick_len  = req_len[i*LEN_W +: LEN_W];
      end
    end
  end

  assign next_ptr  = (owner == PTR_W'(N_REQ - 1)) ? '0 : owner + 1'b1;
  assign mem_rd_en = (state == ST_ISSUE);
  // Address wraps at the top of memory through the natural ADDR_W truncation.
  assign mem_addr  = mem_rd_en ? base + ADDR_W'(iss_cnt) : '0;
  assign issue_acc = mem_rd_en && mem_rd_ready;
  assign last_iss  = (iss_cnt == {1'b0, len});
  assign last_ret  = mem_rvalid && (ret_cnt == {1'b0, len});

  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      rr_ptr    <= PTR_W'(REQ_DATA);
      owner     <= '0;
      gnt       <= '0;
      base      <= '0;
      len       <= '0;
      iss_cnt   <= '0;
      ret_cnt   <= '0;
      rvalid    <= '0;
      rdata     <= '0;
      done      <= '0;
      stray_err <= 1'b0;
    end else begin
      rvalid <= '0;
      done   <= '0;
      case (state)
        ST_IDLE: begin
          if (mem_rvalid) stray_err <= 1'b1;
          if (|req) begin
            gnt     <= pick;
            owner   <= pick_idx;
            base    <= pick_addr;
            len     <= pick_len;
            iss_cnt <= '0;
            ret_cnt <= '0;
            state   <= ST_ISSUE;
          end
        end
        ST_ISSUE, ST_DRAIN: begin
          if (issue_acc) iss_cnt <= iss_cnt + 1'b1;
          if (mem_rvalid) begin
            rvalid  <= gnt;
            rdata   <= mem_rdata;
            ret_cnt <= ret_cnt + 1'b1;
          end
          // The final return beat ends the burst even if it coincides with
          // the final address accept, so DRAIN is skipped in that case.
          if (last_ret) begin
            done   <= gnt;
            gnt    <= '0;
            rr_ptr <= next_ptr;
            state  <= ST_IDLE;
          end else if (issue_acc && last_iss) begin
            state <= ST_DRAIN;
          end
        end
        default: begin
          gnt   <= '0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

  a_gnt_onehot : assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt));

endmodule

// File: tb/tb_fc_rd_arb.sv
// Directed bench for fc_rd_arb: burst-level reference model checked every
// cycle, a latency-programmable memory responder, and literal spot checks.
module tb_fc_rd_arb;
  import fc_pkg::*;

  localparam int N_REQ  = FC_N_REQ;
  localparam int ADDR_W = FC_ADDR_W;
  localparam int DATA_W = FC_DATA_W;
  localparam int LEN_W  = FC_LEN_W;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic [N_REQ-1:0]        req;
  logic [N_REQ*ADDR_W-1:0] req_addr;
  logic [N_REQ*LEN_W-1:0]  req_len;
  logic [N_REQ-1:0]        gnt, rvalid, done;
  logic [DATA_W-1:0]       rdata;
  logic                    mem_rd_en;
  logic [ADDR_W-1:0]       mem_addr;
  logic                    mem_rd_ready = 1'b0;
  logic                    mem_rvalid   = 1'b0;
  logic [DATA_W-1:0]       mem_rdata    = '0;
  logic                    stray_err;

  fc_rd_arb dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req          (req),
    .req_addr     (req_addr),
    .req_len      (req_len),
    .gnt          (gnt),
    .rvalid       (rvalid),
    .rdata        (rdata),
    .done         (done),
    .mem_rd_en    (mem_rd_en),
    .mem_addr     (mem_addr),
    .mem_rd_ready (mem_rd_ready),
    .mem_rvalid   (mem_rvalid),
    .mem_rdata    (mem_rdata),
    .stray_err    (stray_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [DATA_W-1:0] data_of(input logic [ADDR_W-1:0] a);
    return {4'hD, a} ^ 32'h0000_5A5A;
  endfunction

  function automatic logic [N_REQ-1:0] oh(input int i);
    oh = '0;
    if (i >= 0) oh[i] = 1'b1;
  endfunction

  // Burst-level reference: who owns the port, how many beats went out / came back.
  int                m_owner, m_ptr, m_beats, m_issued, m_returned;
  logic [ADDR_W-1:0] m_base;
  logic              m_stray;
  logic [N_REQ-1:0]  e_rvalid, e_done;
  logic [DATA_W-1:0] e_rdata;
  int                c;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_owner = -1; m_ptr = 0; m_beats = 0; m_issued = 0; m_returned = 0;
      m_base = '0; m_stray = 1'b0; e_rvalid = '0; e_done = '0; e_rdata = '0;
    end else begin
      e_rvalid = '0;
      e_done   = '0;
      if (m_owner < 0) begin
        if (mem_rvalid) m_stray = 1'b1;
        for (int k = 0; k < N_REQ; k++) begin
          c = (m_ptr + k) % N_REQ;
          if (m_owner < 0 && req[c]) begin
            m_owner    = c;
            m_base     = req_addr[c*ADDR_W +: ADDR_W];
            m_beats    = int'(req_len[c*LEN_W +: LEN_W]) + 1;
            m_issued   = 0;
            m_returned = 0;
          end
        end
      end else begin
        if (m_issued < m_beats && mem_rd_ready) m_issued++;
        if (mem_rvalid) begin
          e_rvalid = oh(m_owner);
          e_rdata  = mem_rdata;
          m_returned++;
          if (m_returned == m_beats) begin
            e_done  = oh(m_owner);
            m_ptr   = (m_owner + 1) % N_REQ;
            m_owner = -1;
          end
        end
      end
    end
  end

  // Memory responder state: accepted-address log, pending returns, knobs.
  typedef struct {
    int                due;
    logic [ADDR_W-1:0] addr;
  } pend_t;

  pend_t             pend_q[$];
  logic [ADDR_W-1:0] acc_q[$];
  int                cyc = 0;
  int                rv_count = 0;
  int                mem_lat = 1;
  int                ready_mode = 0;
  int                inject_cnt = 0;
  int                inject_done = 0;
  logic              e_en;
  logic [ADDR_W-1:0] e_addr;

  always @(negedge clk) begin
    cyc++;
    if (rst_n) begin
      e_en   = (m_owner >= 0) && (m_issued < m_beats);
      e_addr = m_base + ADDR_W'(m_issued);
      check("gnt", gnt, oh(m_owner));
      check("rvalid", rvalid, e_rvalid);
      check("done", done, e_done);
      check("rdata", rdata, e_rdata);
      check("mem_rd_en", mem_rd_en, e_en);
      if (e_en) check("mem_addr", mem_addr, e_addr);
      check("stray_err", stray_err, m_stray);
      if (rvalid != '0) rv_count++;

      mem_rd_ready = (ready_mode == 0) ? 1'b1 : cyc[0];
      mem_rvalid   = 1'b0;
      if (mem_rd_en && mem_rd_ready) begin
        acc_q.push_back(mem_addr);
        if (mem_lat == 0) begin
          mem_rvalid = 1'b1;
          mem_rdata  = data_of(mem_addr);
        end else begin
          pend_q.push_back('{due: cyc + mem_lat, addr: mem_addr});
        end
      end
      if (pend_q.size() > 0 && pend_q[0].due == cyc) begin
        mem_rvalid = 1'b1;
        mem_rdata  = data_of(pend_q[0].addr);
        void'(pend_q.pop_front());
      end
      if (inject_cnt != inject_done) begin
        mem_rvalid  = 1'b1;
        mem_rdata   = 32'hDEAD_BEEF;
        inject_done = inject_cnt;
      end
    end else begin
      pend_q.delete();
      mem_rvalid   = 1'b0;
      mem_rd_ready = 1'b0;
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [ADDR_W-1:0] a, input logic [LEN_W-1:0] l);
    req_addr[i*ADDR_W +: ADDR_W] = a;
    req_len[i*LEN_W +: LEN_W]    = l;
    req[i]                       = 1'b1;
  endtask

  task automatic wait_done(output logic [N_REQ-1:0] d, input int budget, input string tag);
    d = '0;
    for (int k = 0; k < budget; k++) begin
      step();
      if (done != '0) begin
        d = done;
        return;
      end
    end
    total++;
    bad++;
    $display("FAIL %s: no done within %0d cycles", tag, budget);
  endtask

  task automatic check_addrs(input string tag, input int first, input int n, input logic [ADDR_W-1:0] base);
    logic [ADDR_W-1:0] ea;
    check({tag, "_count"}, acc_q.size() - first, n);
    for (int i = 0; i < n && first + i < acc_q.size(); i++) begin
      ea = base + ADDR_W'(i);
      check({tag, "_addr"}, acc_q[first+i], ea);
    end
  endtask

  logic [N_REQ-1:0] d;
  int               acc0, rv0;
  logic [N_REQ-1:0] rr_done [4] = '{3'b001, 3'b010, 3'b100, 3'b001};
  logic [1:0]       rr_ptrs [4] = '{2'd1, 2'd2, 2'd0, 2'd1};

  initial begin
    rst_n = 1'b0; req = '0; req_addr = '0; req_len = '0;
    repeat (3) step();
    check("rst_gnt", gnt, 3'b000);
    check("rst_rvalid", rvalid, 3'b000);
    check("rst_done", done, 3'b000);
    check("rst_mem_rd_en", mem_rd_en, 1'b0);
    check("rst_mem_addr", mem_addr, 28'h0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_stray", stray_err, 1'b0);
    rst_n = 1'b1;
    step();

    // Round robin: all three held, single-beat bursts.
    mem_lat = 1; ready_mode = 0;
    set_req(REQ_DATA, 28'h10, 8'd0);
    set_req(REQ_WEIGHT, 28'h20, 8'd0);
    set_req(REQ_BIAS, 28'h30, 8'd0);
    for (int k = 0; k < 4; k++) begin
      wait_done(d, 20, "rr_wait");
      check("rr_done_owner", d, rr_done[k]);
      check("rr_ptr", dut.rr_ptr, rr_ptrs[k]);
      if (k == 3) req = '0;
    end
    repeat (2) step();

    // Single data burst, 4 beats, memory latency 2.
    acc0 = acc_q.size(); rv0 = rv_count; mem_lat = 2;
    set_req(REQ_DATA, 28'h100, 8'd3);
    step();
    check("t1_gnt_latency", gnt, 3'b001);
    wait_done(d, 50, "t1_wait");
    req[REQ_DATA] = 1'b0;
    check("t1_done", d, 3'b001);
    check("t1_beats", rv_count - rv0, 4);
    check_addrs("t1", acc0, 4, 28'h100);
    step();
    check("t1_gnt_clear", gnt, 3'b000);
    check("t1_en_clear", mem_rd_en, 1'b0);

    // Backpressure: weight burst of 8 with ready toggling.
    acc0 = acc_q.size(); rv0 = rv_count; mem_lat = 3; ready_mode = 1;
    set_req(REQ_WEIGHT, 28'h2000, 8'd7);
    step();
    check("bp_gnt", gnt, 3'b010);
    wait_done(d, 100, "bp_wait");
    req[REQ_WEIGHT] = 1'b0;
    check("bp_done", d, 3'b010);
    check("bp_beats", rv_count - rv0, 8);
    check_addrs("bp", acc0, 8, 28'h2000);
    ready_mode = 0;
    repeat (2) step();

    // Address wrap with the maximum 256-beat burst.
    acc0 = acc_q.size(); rv0 = rv_count; mem_lat = 1;
    set_req(REQ_DATA, 28'hFFFFFFE, 8'd255);
    wait_done(d, 600, "wrap_wait");
    req[REQ_DATA] = 1'b0;
    check("wrap_done", d, 3'b001);
    check("wrap_beats", rv_count - rv0, 256);
    check("wrap_a1", acc_q[acc0+1], 28'hFFFFFFF);
    check("wrap_a2", acc_q[acc0+2], 28'h0000000);
    check("wrap_last", acc_q[acc0+255], 28'h00000FD);
    check_addrs("wrap", acc0, 256, 28'hFFFFFFE);
    repeat (2) step();

    // Final accept and final return in the same cycle: no drain phase.
    mem_lat = 0;
    set_req(REQ_DATA, 28'h40, 8'd0);
    step();
    check("z_gnt", gnt, 3'b001);
    check("z_en", mem_rd_en, 1'b1);
    check("z_addr", mem_addr, 28'h40);
    step();
    req[REQ_DATA] = 1'b0;
    check("z_done", done, 3'b001);
    check("z_rvalid", rvalid, 3'b001);
    check("z_gnt_clear", gnt, 3'b000);
    check("z_rdata", rdata, data_of(28'h40));
    step();

    // Stray return while idle.
    inject_cnt++;
    step();
    step();
    check("stray_set", stray_err, 1'b1);
    check("stray_no_rvalid", rvalid, 3'b000);
    step();
    check("stray_sticky", stray_err, 1'b1);

    // Reset in the middle of a bias burst.
    rv0 = rv_count; mem_lat = 2;
    set_req(REQ_BIAS, 28'h300, 8'd9);
    for (int k = 0; k < 100 && (rv_count - rv0) < 5; k++) step();
    check("mid_beats", rv_count - rv0, 5);
    rst_n = 1'b0;
    req = '0;
    #1;
    check("mid_gnt", gnt, 3'b000);
    check("mid_rvalid", rvalid, 3'b000);
    check("mid_done", done, 3'b000);
    check("mid_en", mem_rd_en, 1'b0);
    check("mid_addr", mem_addr, 28'h0);
    check("mid_rdata", rdata, 32'h0);
    check("mid_stray", stray_err, 1'b0);
    step();
    check("mid_done_hold", done, 3'b000);
    step();
    set_req(REQ_DATA, 28'h500, 8'd0);
    set_req(REQ_WEIGHT, 28'h600, 8'd0);
    set_req(REQ_BIAS, 28'h700, 8'd0);
    rst_n = 1'b1;
    step();
    check("post_rst_gnt", gnt, 3'b001);
    wait_done(d, 20, "post_rst_wait");
    req = '0;
    check("post_rst_done", d, 3'b001);
    repeat (3) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
